// File: rtl/game_pkg.sv
// Shared game definitions: one-hot action codes, arena/health constants and the
// encoder FSM state type, imported by the encoder and the player blocks.
package game_pkg;

    localparam int unsigned ACT_W = 6;

    // Bit position of each action matches the button wiring on the board.
    localparam logic [ACT_W-1:0] ACT_MOVE_RIGHT = 6'b100000;
    localparam logic [ACT_W-1:0] ACT_MOVE_LEFT  = 6'b010000;
    localparam logic [ACT_W-1:0] ACT_WAIT       = 6'b001000;
    localparam logic [ACT_W-1:0] ACT_JUMP       = 6'b000100;
    localparam logic [ACT_W-1:0] ACT_KICK       = 6'b000010;
    localparam logic [ACT_W-1:0] ACT_PUNCH      = 6'b000001;

    localparam int unsigned LOC_W = 4;
    localparam logic [LOC_W-1:0] LOC_MIN      = 4'd0;
    localparam logic [LOC_W-1:0] LOC_MAX      = 4'd9;
    localparam logic [LOC_W-1:0] LOC_P1_START = 4'd2;
    localparam logic [LOC_W-1:0] LOC_P2_START = 4'd7;

    localparam int unsigned HEALTH_W = 4;
    localparam logic [HEALTH_W-1:0] HEALTH_MAX       = 4'd10;
    localparam logic [HEALTH_W-1:0] HEALTH_PUNCH_DMG = 4'd1;
    localparam logic [HEALTH_W-1:0] HEALTH_KICK_DMG  = 4'd2;

    typedef enum logic [0:0] {
        ST_IDLE    = 1'b0,
        ST_COLLECT = 1'b1
    } enc_state_t;

    // Keeps only the lowest set bit, so PUNCH (bit 0) wins over everything else.
    function automatic logic [ACT_W-1:0] first_press(input logic [ACT_W-1:0] ev);
        return ev & (~ev + ACT_W'(1));
    endfunction

endpackage

// File: rtl/button_debounce.sv
// One button: 2-flop synchronizer, counting debouncer and rising-edge detect.
// press_event is a single-cycle pulse when the debounced level goes 0 -> 1.
module button_debounce #(
    parameter int unsigned DEBOUNCE_CYCLES = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic btn_raw,
    output logic press_event
);

    localparam int unsigned CNT_W = (DEBOUNCE_CYCLES < 2) ? 1 : $clog2(DEBOUNCE_CYCLES + 1);

    logic             sync_q1;
    logic             sync_q2;
    logic             stable_q;
    logic             stable_d;
    logic [CNT_W-1:0] cnt_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            sync_q1  <= 1'b0;
            sync_q2  <= 1'b0;
            stable_q <= 1'b0;
            stable_d <= 1'b0;
            cnt_q    <= '0;
        end else begin
            sync_q1  <= btn_raw;
            sync_q2  <= sync_q1;
            stable_d <= stable_q;
            // Any cycle that agrees with the stable level restarts the count.
            if (sync_q2 != stable_q) begin
                if (cnt_q == CNT_W'(DEBOUNCE_CYCLES - 1)) begin
                    stable_q <= sync_q2;
                    cnt_q    <= '0;
                end else begin
                    cnt_q <= cnt_q + CNT_W'(1);
                end
            end else begin
                cnt_q <= '0;
            end
        end
    end

    assign press_event = stable_q & ~stable_d;

endmodule

// File: rtl/player_action_encoder.sv
// Turns six debounced buttons into one legal one-hot action per game turn,
// holding it for the whole turn and pulsing action_valid when it changes over.
module player_action_encoder
    import game_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES = 4,
    parameter int unsigned TURN_CYCLES     = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             game_active,
    input  logic [ACT_W-1:0] btn_raw,
    output logic [ACT_W-1:0] action,
    output logic             action_valid,
    output logic             press_pending
);

    localparam int unsigned TURN_W = (TURN_CYCLES < 2) ? 1 : $clog2(TURN_CYCLES);

    enc_state_t        state_q;
    logic [TURN_W-1:0] turn_cnt_q;
    logic [ACT_W-1:0]  latch_q;
    logic              latch_valid_q;
    logic [ACT_W-1:0]  last_action_q;
    logic [ACT_W-1:0]  action_q;
    logic              action_valid_q;

    logic [ACT_W-1:0]  press_ev;
    logic [ACT_W-1:0]  press_first;
    logic [ACT_W-1:0]  issue_code;
    logic              at_boundary;

    for (genvar i = 0; i < ACT_W; i++) begin : g_btn
        button_debounce #(
            .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
        ) u_debounce (
            .clk        (clk),
            .rst        (rst),
            .btn_raw    (btn_raw[i]),
            .press_event(press_ev[i])
        );
    end

    assign press_first = first_press(press_ev);
    assign at_boundary = (turn_cnt_q == TURN_W'(TURN_CYCLES - 1));

    // Two JUMPs in a row are not allowed; the second one becomes WAIT.
    always_comb begin
        issue_code = latch_valid_q ? latch_q : ACT_WAIT;
        if ((issue_code == ACT_JUMP) && (last_action_q == ACT_JUMP)) begin
            issue_code = ACT_WAIT;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q        <= ST_IDLE;
            turn_cnt_q     <= '0;
            latch_q        <= '0;
            latch_valid_q  <= 1'b0;
            last_action_q  <= '0;
            action_q       <= ACT_WAIT;
            action_valid_q <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    turn_cnt_q     <= '0;
                    latch_q        <= '0;
                    latch_valid_q  <= 1'b0;
                    last_action_q  <= '0;
                    action_q       <= ACT_WAIT;
                    action_valid_q <= 1'b0;
                    if (game_active) begin
                        state_q <= ST_COLLECT;
                    end
                end
                ST_COLLECT: begin
                    if (!game_active) begin
                        state_q        <= ST_IDLE;
                        turn_cnt_q     <= '0;
                        latch_q        <= '0;
                        latch_valid_q  <= 1'b0;
                        last_action_q  <= '0;
                        action_q       <= ACT_WAIT;
                        action_valid_q <= 1'b0;
                    end else if (at_boundary) begin
                        turn_cnt_q     <= '0;
                        action_q       <= issue_code;
                        last_action_q  <= issue_code;
                        action_valid_q <= 1'b1;
                        // A press landing on the boundary cycle opens the next turn's latch.
                        latch_q        <= press_first;
                        latch_valid_q  <= |press_ev;
                    end else begin
                        turn_cnt_q     <= turn_cnt_q + TURN_W'(1);
                        action_valid_q <= 1'b0;
                        if (!latch_valid_q && (|press_ev)) begin
                            latch_q       <= press_first;
                            latch_valid_q <= 1'b1;
                        end
                    end
                end
                default: begin
                    state_q        <= ST_IDLE;
                    action_q       <= ACT_WAIT;
                    action_valid_q <= 1'b0;
                end
            endcase
        end
    end

    assign action        = action_q;
    assign action_valid  = action_valid_q;
    assign press_pending = latch_valid_q;

endmodule

// File: tb/tb_player_action_encoder.sv
// Scoreboard bench for player_action_encoder: each scenario queues the actions it
// expects per turn; a negedge monitor pops and compares on every action_valid.
module tb_player_action_encoder;
    import game_pkg::*;

    logic       clk;
    logic       rst;
    logic       game_active;
    logic [5:0] btn_raw;
    logic [5:0] action;
    logic       action_valid;
    logic       press_pending;

    int         vectors;
    int         miscompares;
    logic       mon_en;
    logic [5:0] exp_q[$];

    player_action_encoder #(
        .DEBOUNCE_CYCLES(4),
        .TURN_CYCLES    (16)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .game_active  (game_active),
        .btn_raw      (btn_raw),
        .action       (action),
        .action_valid (action_valid),
        .press_pending(press_pending)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Scoreboard: every action_valid must match the oldest queued expectation.
    always @(negedge clk) begin
        if (mon_en) begin
            vectors++;
            if ($countones(action) != 1) begin
                miscompares++;
                $display("FAIL onehot: action=%b is not one-hot", action);
            end
            if (action_valid) begin
                vectors++;
                if (exp_q.size() == 0) begin
                    miscompares++;
                    $display("FAIL unexpected_valid: action=%b with nothing queued", action);
                end else begin
                    logic [5:0] exp_act;
                    exp_act = exp_q.pop_front();
                    if (action !== exp_act) begin
                        miscompares++;
                        $display("FAIL turn_action: got %b expected %b", action, exp_act);
                    end
                end
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic wait_valid(input string tag, output int n);
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!action_valid && n < 64);
        if (!action_valid) begin
            vectors++;
            miscompares++;
            $display("FAIL %s: no action_valid within %0d cycles", tag, n);
        end
    endtask

    task automatic test_reset();
        int n;
        rst = 1'b1;
        game_active = 1'b1;
        btn_raw = '0;
        mon_en = 1'b0;
        repeat (2) @(negedge clk);
        vectors++;
        if (action !== ACT_WAIT) begin
            miscompares++;
            $display("FAIL reset_action: got %b expected %b", action, ACT_WAIT);
        end
        vectors++;
        if (action_valid !== 1'b0) begin
            miscompares++;
            $display("FAIL reset_valid: got %b expected 0", action_valid);
        end
        vectors++;
        if (press_pending !== 1'b0) begin
            miscompares++;
            $display("FAIL reset_pending: got %b expected 0", press_pending);
        end
        rst = 1'b0;
        mon_en = 1'b1;
        exp_q.push_back(ACT_WAIT);
        // One cycle to leave IDLE, then a full 16-cycle turn.
        wait_valid("reset_first_turn", n);
        vectors++;
        if (n != 17) begin
            miscompares++;
            $display("FAIL reset_turn_len: got %0d cycles expected 17", n);
        end
    endtask

    task automatic test_punch();
        int n;
        exp_q.push_back(ACT_PUNCH);
        exp_q.push_back(ACT_WAIT);
        repeat (2) @(negedge clk);
        btn_raw[0] = 1'b1;
        repeat (10) @(negedge clk);
        btn_raw[0] = 1'b0;
        vectors++;
        if (press_pending !== 1'b1) begin
            miscompares++;
            $display("FAIL punch_pending: got %b expected 1", press_pending);
        end
        wait_valid("punch_turn", n);
        for (int i = 0; i < 15; i++) begin
            @(negedge clk);
            vectors++;
            if (action !== ACT_PUNCH || action_valid !== 1'b0) begin
                miscompares++;
                $display("FAIL punch_hold: cycle %0d action=%b valid=%b expected %b valid 0",
                         i + 1, action, action_valid, ACT_PUNCH);
            end
        end
        wait_valid("punch_next_turn", n);
        vectors++;
        if (n != 1) begin
            miscompares++;
            $display("FAIL punch_turn_len: next valid after %0d extra cycles expected 1", n);
        end
    endtask

    task automatic test_glitch();
        int n;
        exp_q.push_back(ACT_WAIT);
        repeat (2) @(negedge clk);
        btn_raw[1] = 1'b1;
        repeat (3) @(negedge clk);
        btn_raw[1] = 1'b0;
        repeat (8) @(negedge clk);
        vectors++;
        if (press_pending !== 1'b0) begin
            miscompares++;
            $display("FAIL glitch_pending: got %b expected 0", press_pending);
        end
        wait_valid("glitch_turn", n);
    endtask

    task automatic test_priority();
        int n;
        exp_q.push_back(ACT_KICK);
        repeat (2) @(negedge clk);
        btn_raw = 6'b100010;
        repeat (3) @(negedge clk);
        btn_raw = 6'b110010;
        repeat (8) @(negedge clk);
        vectors++;
        if (press_pending !== 1'b1) begin
            miscompares++;
            $display("FAIL priority_pending: got %b expected 1", press_pending);
        end
        btn_raw = '0;
        wait_valid("priority_turn", n);
    endtask

    task automatic test_jump();
        int n;
        logic [5:0] exp_seq[3];
        exp_seq[0] = ACT_JUMP;
        exp_seq[1] = ACT_WAIT;
        exp_seq[2] = ACT_JUMP;
        for (int t = 0; t < 3; t++) begin
            exp_q.push_back(exp_seq[t]);
            repeat (2) @(negedge clk);
            btn_raw[2] = 1'b1;
            repeat (8) @(negedge clk);
            vectors++;
            if (press_pending !== 1'b1) begin
                miscompares++;
                $display("FAIL jump_pending: turn %0d got %b expected 1", t, press_pending);
            end
            btn_raw[2] = 1'b0;
            wait_valid("jump_turn", n);
        end
    endtask

    task automatic test_abort(input bit use_rst);
        int n;
        // Prep turn so the held action differs from WAIT before the abort.
        exp_q.push_back(ACT_KICK);
        repeat (2) @(negedge clk);
        btn_raw[1] = 1'b1;
        repeat (8) @(negedge clk);
        btn_raw[1] = 1'b0;
        wait_valid("abort_prep", n);
        btn_raw[0] = 1'b1;
        repeat (8) @(negedge clk);
        vectors++;
        if (press_pending !== 1'b1) begin
            miscompares++;
            $display("FAIL abort_pending: use_rst=%0d got %b expected 1", use_rst, press_pending);
        end
        btn_raw = '0;
        if (use_rst) rst = 1'b1;
        else game_active = 1'b0;
        @(negedge clk);
        vectors++;
        if (action !== ACT_WAIT || action_valid !== 1'b0 || press_pending !== 1'b0) begin
            miscompares++;
            $display("FAIL abort_state: use_rst=%0d action=%b valid=%b pending=%b expected %b 0 0",
                     use_rst, action, action_valid, press_pending, ACT_WAIT);
        end
        if (use_rst) rst = 1'b0;
        else game_active = 1'b1;
        exp_q.push_back(ACT_WAIT);
        wait_valid("abort_restart", n);
        vectors++;
        if (n != 17) begin
            miscompares++;
            $display("FAIL abort_turn_len: use_rst=%0d got %0d cycles expected 17", use_rst, n);
        end
    endtask

    initial begin
        vectors = 0;
        miscompares = 0;
        mon_en = 1'b0;
        rst = 1'b1;
        game_active = 1'b0;
        btn_raw = '0;
        test_reset();
        test_punch();
        test_glitch();
        test_priority();
        test_jump();
        test_abort(1'b0);
        test_abort(1'b1);
        @(negedge clk);
        vectors++;
        if (exp_q.size() != 0) begin
            miscompares++;
            $display("FAIL queue_drain: %0d expected actions never issued", exp_q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
